// File: rtl/pushbutton_debounce_bank_if.sv
// Signal bundle between raw pushbuttons and the debounce bank.
// The master side drives the raw buttons; the slave side (the bank) returns clean levels and strobes.
interface pushbutton_debounce_bank_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] repeat_pulse;
  logic               any_press;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, repeat_pulse, any_press
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, repeat_pulse, any_press
  );
endinterface

// File: rtl/pushbutton_debounce_bank.sv
// Bank of independent pushbutton conditioners: synchroniser, counter debounce,
// polarity-normalised level, one-cycle press/release strobes and optional auto-repeat.
module pushbutton_debounce_bank #(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  pushbutton_debounce_bank_if.slave bus
);

  localparam int              DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic            IDLE     = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0]   CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_BTN];
  logic [DW-1:0]          cnt_q  [NUM_BTN];
  logic [NUM_BTN-1:0]     level_q;
  logic [NUM_BTN-1:0]     press_q;
  logic [NUM_BTN-1:0]     release_q;
  logic [NUM_BTN-1:0]     repeat_q;
  logic [NUM_BTN-1:0]     pressed;
  logic [NUM_BTN-1:0]     accept;

  // accept: the differing synced value completes its hold this edge
  always_comb begin
    pressed = '0;
    accept  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      pressed[i] = sync_q[i][SYNC_STAGES-1] ^ IDLE;
      accept[i]  = (pressed[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        sync_q[i] <= {SYNC_STAGES{IDLE}};
        cnt_q[i]  <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        sync_q[i]    <= {sync_q[i][SYNC_STAGES-2:0], bus.btn_raw[i]};
        press_q[i]   <= accept[i] & ~level_q[i];
        release_q[i] <= accept[i] &  level_q[i];
        if (pressed[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          level_q[i] <= pressed[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt_q [NUM_BTN];

    // Counts down to the next strobe (delay after press, then period) rather than
    // up against thresholds; strobe timing is identical.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < NUM_BTN; i++) rcnt_q[i] <= '0;
        repeat_q <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
          repeat_q[i] <= 1'b0;
          if (accept[i] && !level_q[i]) begin
            rcnt_q[i] <= RW'(REPEAT_DELAY - 1);
          end else if (!level_q[i] || accept[i]) begin
            rcnt_q[i] <= '0;
          end else if (rcnt_q[i] == '0) begin
            repeat_q[i] <= 1'b1;
            rcnt_q[i]   <= RW'(REPEAT_PERIOD - 1);
          end else begin
            rcnt_q[i] <= rcnt_q[i] - 1'b1;
          end
        end
      end
    end
  end else begin : g_no_repeat
    assign repeat_q = '0;
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.any_press     = |press_q;

endmodule
